bht_update: RTL and testbench
=============================

// Module: bht_update
// PURPOSE
//  Branch history + BTB update controller between the EX stage and btb.
//  Holds a table of 2-bit saturating direction counters, indexed by PC low bits.
//  Combines the fetch-stage btb_hit with the counter to give pred_taken.
//  From each resolved EX branch it:
//   - updates the counter,
//   - issues one registered BTB write command (web/waddr/wr_data),
//   - keeps branch and mispredict statistics.
// PARAMETERS
//  BHT_ADDR_LEN  7  index width; table depth = 1<<BHT_ADDR_LEN; index = pc[BHT_ADDR_LEN-1:0]
// PORTS
//  clk             in   1   clock; all state updates on rising edge
//  rst             in   1   synchronous, active-high reset
//  raddr           in   32  fetch PC (same value driven to btb.raddr)
//  btb_hit         in   1   btb.btb_hit for raddr
//  pred_taken      out  1   fetch prediction: btb_hit & cnt[raddr idx][1] (combinational)
//  ex_br_valid     in   1   a branch is resolved in EX this cycle
//  ex_pc           in   32  PC of the resolved branch
//  ex_taken        in   1   actual direction
//  ex_target       in   32  actual target address
//  ex_btb_hit      in   1   btb_hit seen at fetch, piped to EX
//  ex_pred_taken   in   1   pred_taken seen at fetch, piped to EX
//  ex_pred_target  in   32  btb.rd_data seen at fetch, piped to EX
//  web             out  2   BTB command: 00 none, 01 update target, 10 add entry, 11 invalidate
//  waddr           out  32  BTB write address (= ex_pc)
//  wr_data         out  32  BTB write data (= ex_target)
//  br_count        out  32  resolved branches since reset
//  mispred_count   out  32  mispredicted branches since reset
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - all counters -> 01 (weakly not-taken); web/waddr/wr_data/br_count/mispred_count -> 0.
//   - An in-flight ex_br_valid in the reset cycle is dropped: no counter change, web stays 00.
//  Counter encoding: 00 SN, 01 WN, 10 WT, 11 ST.
//   - On ex_br_valid: taken -> +1, saturates at 11; not-taken -> -1, saturates at 00.
//   - Index for the update = ex_pc[BHT_ADDR_LEN-1:0]; no tag, aliasing allowed.
//  Fetch read is combinational from the current table contents.
//   - Same-index read and write in one cycle: pred_taken uses the pre-edge value (no bypass).
//  BTB command, registered: valid the cycle after ex_br_valid, held exactly 1 cycle.
//   Evaluated in priority order, using old = counter before this update:
//   - ex_taken & !ex_btb_hit                                 -> 10 (add)
//   - ex_taken & ex_btb_hit & ex_pred_target != ex_target    -> 01 (update)
//   - !ex_taken & ex_btb_hit & old == 00                     -> 11 (invalidate)
//   - otherwise, or ex_br_valid=0                            -> 00
//   - waddr/wr_data load ex_pc/ex_target whenever ex_br_valid=1; otherwise they hold.
//   - Back-to-back ex_br_valid gives back-to-back commands, one per cycle, no stall.
//  Mispredict for a valid branch = (ex_pred_taken != ex_taken)
//    | (ex_taken & ex_pred_taken & ex_pred_target != ex_target).
//  Statistics:
//   - br_count +1 per ex_br_valid; mispred_count +1 per mispredict.
//   - Both saturate at 32'hFFFF_FFFF.
//   - Both are registered: visible the cycle after the branch.
//  Consecutive updates to one index accumulate each cycle (00->01->10 over 2 taken branches).
// TESTING
//  1 Reset, then raddr=0x40, btb_hit=1 -> pred_taken=0 (cnt=01); web=0; counts=0.
//  2 ex_br_valid, ex_pc=0x40, taken, target=0x80, ex_btb_hit=0
//    -> next cycle: web=10, waddr=0x40, wr_data=0x80; br_count=1, mispred_count=0;
//       the cycle after: web=00.
//  3 Two more taken updates on idx of 0x40 (cnt 10->11->11)
//    -> pred_taken=1 with btb_hit=1; stays 11 on a 4th taken update (saturation).
//  4 hit, pred_taken=1, taken, ex_pred_target=0x80, ex_target=0x90
//    -> web=01, wr_data=0x90, mispred_count +1.
//  5 cnt=00, ex_btb_hit=1, not taken -> web=11, counter stays 00;
//    same case with cnt=01 -> web=00, cnt=00.
//  6 rst asserted in the same cycle as ex_br_valid
//    -> web=00 next cycle, counters all 01, br_count=0;
//    same-index read during an update returns the old counter.

Source files
------------

// File: rtl/bht_update.sv
// rtl/bht_update.sv - branch history table and BTB update controller between EX and btb
module bht_update #(
  parameter int BHT_ADDR_LEN = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] raddr,
  input  logic        btb_hit,
  output logic        pred_taken,
  input  logic        ex_br_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_btb_hit,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic [1:0]  web,
  output logic [31:0] waddr,
  output logic [31:0] wr_data,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int DEPTH = 1 << BHT_ADDR_LEN;

  localparam logic [1:0] CNT_SN = 2'b00;
  localparam logic [1:0] CNT_WN = 2'b01;
  localparam logic [1:0] CNT_ST = 2'b11;

  localparam logic [1:0] WEB_NONE  = 2'b00;
  localparam logic [1:0] WEB_UPD   = 2'b01;
  localparam logic [1:0] WEB_ADD   = 2'b10;
  localparam logic [1:0] WEB_INVAL = 2'b11;

  logic [1:0]  cnt_q [DEPTH];
  logic [1:0]  web_q, web_d;
  logic [31:0] waddr_q, wr_data_q;
  logic [31:0] br_count_q, mispred_count_q;

  logic [BHT_ADDR_LEN-1:0] rd_idx, ex_idx;
  logic [1:0]              old_cnt, new_cnt;
  logic                    target_diff;
  logic                    mispred;
  logic                    unused_addr_bits;

  assign rd_idx  = raddr[BHT_ADDR_LEN-1:0];
  assign ex_idx  = ex_pc[BHT_ADDR_LEN-1:0];
  assign old_cnt = cnt_q[ex_idx];

  // PC bits above the index are intentionally ignored: the table is untagged
  assign unused_addr_bits = ^{raddr[31:BHT_ADDR_LEN], ex_pc[31:BHT_ADDR_LEN]};

  // Fetch prediction reads the table as it stands before this edge's update (no bypass)
  assign pred_taken = btb_hit & cnt_q[rd_idx][1];

  assign target_diff = (ex_pred_target != ex_target);
  assign mispred     = (ex_pred_taken != ex_taken) | (ex_taken & ex_pred_taken & target_diff);

  // Next counter value and BTB command derived from the pre-update counter
  always_comb begin
    new_cnt = old_cnt;
    web_d   = WEB_NONE;
    if (ex_taken) begin
      if (old_cnt != CNT_ST) new_cnt = old_cnt + 2'd1;
    end else begin
      if (old_cnt != CNT_SN) new_cnt = old_cnt - 2'd1;
    end
    if (ex_br_valid) begin
      if (ex_taken && !ex_btb_hit)                   web_d = WEB_ADD;
      else if (ex_taken && ex_btb_hit && target_diff) web_d = WEB_UPD;
      else if (!ex_taken && ex_btb_hit && old_cnt == CNT_SN) web_d = WEB_INVAL;
      else                                            web_d = WEB_NONE;
    end
  end

  // Direction counter table; reset wins over an in-flight resolved branch
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_WN;
    end else if (ex_br_valid) begin
      cnt_q[ex_idx] <= new_cnt;
    end
  end

  // Registered one-cycle BTB command; address/data hold between branches
  always_ff @(posedge clk) begin
    if (rst) begin
      web_q     <= WEB_NONE;
      waddr_q   <= '0;
      wr_data_q <= '0;
    end else begin
      web_q <= web_d;
      if (ex_br_valid) begin
        waddr_q   <= ex_pc;
        wr_data_q <= ex_target;
      end
    end
  end

  // Saturating branch and mispredict statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else if (ex_br_valid) begin
      if (br_count_q != '1) br_count_q <= br_count_q + 32'd1;
      if (mispred && mispred_count_q != '1) mispred_count_q <= mispred_count_q + 32'd1;
    end
  end

  assign web           = web_q;
  assign waddr         = waddr_q;
  assign wr_data       = wr_data_q;
  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_bht_update.sv
// tb/tb_bht_update.sv - randomized self-checking bench for bht_update against a table model
module tb_bht_update;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] raddr;
  logic        btb_hit;
  logic        pred_taken;
  logic        ex_br_valid;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_btb_hit;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [1:0]  web;
  logic [31:0] waddr;
  logic [31:0] wr_data;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  bht_update #(.BHT_ADDR_LEN(7)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .btb_hit(btb_hit), .pred_taken(pred_taken),
    .ex_br_valid(ex_br_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_btb_hit(ex_btb_hit), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .web(web), .waddr(waddr), .wr_data(wr_data), .br_count(br_count),
    .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: counter strength per index as a plain integer 0..3
  int          m_cnt [128];
  int          e_web;
  logic [31:0] e_waddr, e_wr_data;
  longint      e_br, e_mis;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit v, input logic [31:0] pc, input bit tk,
                       input logic [31:0] tg, input bit bh, input bit pt,
                       input logic [31:0] ptg, input logic [31:0] ra, input bit fh);
    int idx, old;
    rst = r; ex_br_valid = v; ex_pc = pc; ex_taken = tk; ex_target = tg;
    ex_btb_hit = bh; ex_pred_taken = pt; ex_pred_target = ptg;
    raddr = ra; btb_hit = fh;
    #1;
    check("pred_taken", {31'd0, pred_taken}, {31'd0, fh && (m_cnt[ra % 128] >= 2)});
    @(posedge clk);
    if (r) begin
      foreach (m_cnt[i]) m_cnt[i] = 1;
      e_web = 0; e_waddr = 0; e_wr_data = 0; e_br = 0; e_mis = 0;
    end else if (v) begin
      idx = pc % 128;
      old = m_cnt[idx];
      if (tk && !bh)                  e_web = 2;
      else if (tk && bh && ptg != tg) e_web = 1;
      else if (!tk && bh && old == 0) e_web = 3;
      else                            e_web = 0;
      e_waddr = pc; e_wr_data = tg;
      if (e_br < 64'hFFFF_FFFF) e_br++;
      if (((pt != tk) || (tk && pt && ptg != tg)) && e_mis < 64'hFFFF_FFFF) e_mis++;
      m_cnt[idx] = tk ? ((old == 3) ? 3 : old + 1) : ((old == 0) ? 0 : old - 1);
    end else begin
      e_web = 0;
    end
    @(negedge clk);
    check("web", {30'd0, web}, e_web);
    check("waddr", waddr, e_waddr);
    check("wr_data", wr_data, e_wr_data);
    check("br_count", br_count, e_br[31:0]);
    check("mispred_count", mispred_count, e_mis[31:0]);
  endtask

  function automatic logic [31:0] pick_pc();
    logic [31:0] base;
    base = 32'h0000_0040;
    return base + 32'($urandom_range(0, 5)) * 4 + 32'($urandom_range(0, 1)) * 32'h200;
  endfunction

  initial begin
    foreach (m_cnt[i]) m_cnt[i] = 1;
    e_web = 0; e_waddr = 0; e_wr_data = 0; e_br = 0; e_mis = 0;
    rst = 1'b1; ex_br_valid = 0; ex_pc = 0; ex_taken = 0; ex_target = 0;
    ex_btb_hit = 0; ex_pred_taken = 0; ex_pred_target = 0; raddr = 0; btb_hit = 0;
    @(negedge clk);

    // reset and the scenario walk-through
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 32'h40, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 32'h40, 1);
    cycle(0, 1, 32'h40, 1, 32'h80, 0, 0, 0, 32'h40, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 32'h40, 1);
    cycle(0, 1, 32'h40, 1, 32'h80, 1, 1, 32'h80, 32'h40, 1);
    cycle(0, 1, 32'h40, 1, 32'h80, 1, 1, 32'h80, 32'h40, 1);
    cycle(0, 1, 32'h40, 1, 32'h80, 1, 1, 32'h80, 32'h40, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 32'h40, 1);
    cycle(0, 1, 32'h40, 1, 32'h90, 1, 1, 32'h80, 32'h40, 1);
    cycle(0, 1, 32'h44, 0, 32'h10, 1, 0, 32'h10, 32'h44, 1);
    cycle(0, 1, 32'h44, 0, 32'h10, 1, 0, 32'h10, 32'h44, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 32'h44, 1);
    cycle(1, 1, 32'h40, 1, 32'h80, 0, 0, 0, 32'h40, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 32'h40, 1);

    // randomized traffic on a few aliasing PCs, with occasional reset
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] pc, tg, ptg, ra;
      bit r, v, tk, bh, pt;
      pc  = pick_pc();
      ra  = ($urandom_range(0, 2) == 0) ? pc : pick_pc();
      tg  = 32'h1000 + 32'($urandom_range(0, 2)) * 16;
      ptg = 32'h1000 + 32'($urandom_range(0, 2)) * 16;
      r   = ($urandom_range(0, 199) == 0);
      v   = ($urandom_range(0, 3) != 0);
      tk  = 1'($urandom_range(0, 1));
      bh  = 1'($urandom_range(0, 1));
      pt  = 1'($urandom_range(0, 1));
      cycle(r, v, pc, tk, tg, bh, pt, ptg, ra, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
